// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle RV64 phase sequencer.
//   - state_e  : sequencer FSM states
//   - PH_*     : phase codes presented on the phase output
//   - OP_*     : RV64 major opcodes recognised by the core
//   - err_e    : sticky error codes
//   - helpers  : opcode legality, memory-op detection, state-to-phase map
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] PH_FETCH  = 3'd0;
  localparam logic [2:0] PH_DECODE = 3'd1;
  localparam logic [2:0] PH_EXEC   = 3'd2;
  localparam logic [2:0] PH_MEM    = 3'd3;
  localparam logic [2:0] PH_WB     = 3'd4;
  localparam logic [2:0] PH_IDLE   = 3'd7;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_IMEM_TO = 2'd2,
    ERR_DMEM_TO = 2'd3
  } err_e;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
      OP_JALR, OP_LUI, OP_AUIPC, OP_OP32, OP_IMM32, OP_SYSTEM: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic [2:0] phase_of(input state_e s);
    case (s)
      S_FETCH:  return PH_FETCH;
      S_DECODE: return PH_DECODE;
      S_EXEC:   return PH_EXEC;
      S_MEM:    return PH_MEM;
      S_WB:     return PH_WB;
      default:  return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// seq_wait_timer: counts consecutive un-acknowledged memory request cycles.
//   clk, rst  : clock, async active-high reset
//   req_i     : a request is outstanding this cycle
//   ack_i     : the memory acknowledges this cycle
//   clr_i     : restart the count (sequencer changes state)
//   expire_o  : this is the MAX_WAIT-th un-acked cycle; an ack in the same
//               cycle suppresses it so the transfer wins over the timeout
module seq_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic ack_i,
  input  logic clr_i,
  output logic expire_o
);

  // Holds the number of earlier stalled cycles, so MAX_WAIT-1 suffices.
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [CW-1:0] cnt_q;
  logic          stall;

  assign stall    = req_i & ~ack_i;
  assign expire_o = stall & (cnt_q == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (stall) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: phase controller for the five-phase multicycle RV64
// core. Sequences FETCH/DECODE/EXEC/MEM/WB, stalls on memory handshakes,
// halts on ECALL, halt request, illegal opcode or memory timeout.
//   run, halt_req         : start level / stop request (instruction boundary)
//   opcode                : current instruction opcode, valid from DECODE
//   imem_req/imem_ack     : instruction fetch handshake
//   dmem_req/dmem_ack     : data access handshake (loads/stores only)
//   phase                 : 0..4 active phase, 7 when idle or halted
//   opnd_en .. pc_en      : one-cycle datapath latch enables
//   busy, halted, err     : status; err is sticky until rst
//   cycle_cnt, instret    : busy-cycle and retired-instruction counters
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic [6:0]       opcode,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic [2:0]       phase,
  output logic             opnd_en,
  output logic             aluout_en,
  output logic             wb_en,
  output logic             rf_we_en,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  err_e             err_q, err_d;
  logic             mem_op_q;      // current instruction is a load/store
  logic             halt_pend_q;   // halt_req seen since the last WB
  logic [2:0]       phase_q;
  logic             imem_req_q, dmem_req_q, opnd_en_q, aluout_en_q;
  logic             mem_phase_q, rf_we_en_q, pc_en_q, busy_q, halted_q;
  logic [CNT_W-1:0] cycle_cnt_q, instret_q;

  logic wait_req, wait_ack, wait_expire, state_chg, stop_at_wb;

  // The timer watches whichever handshake the current state is waiting on.
  assign wait_req  = (state_q == S_FETCH) | ((state_q == S_MEM) & mem_op_q);
  assign wait_ack  = (state_q == S_FETCH) ? imem_ack : dmem_ack;
  assign state_chg = (state_d != state_q);

  seq_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .req_i    (wait_req),
    .ack_i    (wait_ack),
    .clr_i    (state_chg),
    .expire_o (wait_expire)
  );

  assign stop_at_wb = (opcode == OP_SYSTEM) | halt_pend_q | halt_req;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_expire) begin
          state_d = S_HALT;
          if (err_q == ERR_NONE) err_d = ERR_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (is_legal_op(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          if (err_q == ERR_NONE) err_d = ERR_ILLEGAL;
        end
      end
      S_EXEC:   state_d = S_MEM;
      S_MEM: begin
        if (!mem_op_q || dmem_ack) begin
          state_d = S_WB;
        end else if (wait_expire) begin
          state_d = S_HALT;
          if (err_q == ERR_NONE) err_d = ERR_DMEM_TO;
        end
      end
      S_WB:     state_d = stop_at_wb ? S_HALT : S_FETCH;
      S_HALT:   if (!run) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean flop
  // that changes together with the state it decodes.
  // NOTE: the reset branch is asynchronous so a reset mid-instruction drops
  // every enable immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      err_q       <= ERR_NONE;
      mem_op_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      phase_q     <= PH_IDLE;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      opnd_en_q   <= 1'b0;
      aluout_en_q <= 1'b0;
      mem_phase_q <= 1'b0;
      rf_we_en_q  <= 1'b0;
      pc_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == S_DECODE) mem_op_q <= is_mem_op(opcode);
      halt_pend_q <= (state_q == S_WB) ? 1'b0 : (halt_pend_q | halt_req);

      phase_q     <= phase_of(state_d);
      imem_req_q  <= (state_d == S_FETCH);
      dmem_req_q  <= (state_d == S_MEM) & mem_op_q;
      opnd_en_q   <= (state_d == S_DECODE);
      aluout_en_q <= (state_d == S_EXEC);
      mem_phase_q <= (state_d == S_MEM);
      rf_we_en_q  <= (state_d == S_WB);
      pc_en_q     <= (state_d == S_WB);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q    <= (state_d == S_HALT);

      if (busy_q)            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (state_q == S_WB)   instret_q   <= instret_q + CNT_W'(1);
    end
  end

  assign phase     = phase_q;
  assign imem_req  = imem_req_q;
  assign dmem_req  = dmem_req_q;
  assign opnd_en   = opnd_en_q;
  assign aluout_en = aluout_en_q;
  // The writeback latch must close on the acked MEM cycle only, so it is the
  // one enable that also looks at the live dmem_ack.
  assign wb_en     = mem_phase_q & (~mem_op_q | dmem_ack);
  assign rf_we_en  = rf_we_en_q;
  assign pc_en     = pc_en_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign err       = err_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. A transaction-level model
// turns instruction descriptors (opcode, fetch delay, data delay) into a
// per-cycle timeline of inputs and expected outputs, which is then replayed
// against the DUT open-loop.
module tb_multicycle_sequencer;

  localparam int MAX_WAIT = 16;
  localparam int P_IDLE   = 5;
  localparam int P_HALT   = 6;
  localparam logic [13:0] RESET_OUT = 14'h3800;  // phase 7, everything else 0

  localparam bit [6:0] IMM    = 7'b0010011;
  localparam bit [6:0] LOAD   = 7'b0000011;
  localparam bit [6:0] STORE  = 7'b0100011;
  localparam bit [6:0] SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst, run, halt_req, imem_ack, dmem_ack;
  logic [6:0]  opcode;
  logic        imem_req, dmem_req, opnd_en, aluout_en, wb_en, rf_we_en, pc_en;
  logic        busy, halted;
  logic [2:0]  phase;
  logic [1:0]  err;
  logic [63:0] cycle_cnt, instret;

  multicycle_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .halt_req  (halt_req),
    .opcode    (opcode),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .dmem_req  (dmem_req),
    .dmem_ack  (dmem_ack),
    .phase     (phase),
    .opnd_en   (opnd_en),
    .aluout_en (aluout_en),
    .wb_en     (wb_en),
    .rf_we_en  (rf_we_en),
    .pc_en     (pc_en),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .cycle_cnt (cycle_cnt),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          run, hr, ia, da;
    bit [6:0]    op;
    bit [13:0]   expv;
    longint unsigned ccnt, iret;
  } cyc_t;

  cyc_t tl[$];

  bit [6:0] legal_ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                              7'b0010111, 7'b0111011, 7'b0011011, 7'b1110011};

  // Model state.
  bit              pend;
  bit [1:0]        err_m;
  longint unsigned busy_n, ret_n;
  bit              hr_en;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint unsigned act, input longint unsigned expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, expv);
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic bit rhr();
    return hr_en && ($urandom_range(0, 24) == 0);
  endfunction

  function automatic bit legal(input bit [6:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [13:0] outv();
    return {phase, imem_req, dmem_req, opnd_en, aluout_en, wb_en, rf_we_en,
            pc_en, busy, halted, err};
  endfunction

  // One cycle of the timeline. ph: 0..4 active phases, P_IDLE, P_HALT.
  task automatic emit(input int ph, input bit dreq, input bit wbe, input bit rn,
                      input bit hr, input bit ia, input bit da, input bit [6:0] op);
    cyc_t     c;
    bit [2:0] pv;
    pv     = (ph <= 4) ? ph[2:0] : 3'd7;
    c.run  = rn;
    c.hr   = hr;
    c.ia   = ia;
    c.da   = da;
    c.op   = op;
    c.expv = {pv, ph == 0, dreq, ph == 1, ph == 2, wbe, ph == 4, ph == 4,
              ph <= 4, ph == P_HALT, err_m};
    c.ccnt = busy_n;
    c.iret = ret_n;
    tl.push_back(c);
    if (ph <= 4) busy_n++;
    if (ph == 4) ret_n++;
    pend = (ph == 4) ? 1'b0 : (pend | hr);
  endtask

  task automatic new_seg();
    tl.delete();
    pend   = 1'b0;
    err_m  = 2'd0;
    busy_n = 0;
    ret_n  = 0;
  endtask

  // From IDLE: a few idle cycles, then run.
  task automatic start_run();
    int m = $urandom_range(1, 3);
    repeat (m) emit(P_IDLE, 0, 0, 0, rhr(), rb(), rb(), rop());
    emit(P_IDLE, 0, 0, 1, rhr(), rb(), rb(), rop());
  endtask

  // From HALT: linger with run high, drop run, idle, restart.
  task automatic halt_idle_run();
    int n = $urandom_range(0, 2);
    repeat (n) emit(P_HALT, 0, 0, 1, rhr(), rb(), rb(), rop());
    emit(P_HALT, 0, 0, 0, rhr(), rb(), rb(), rop());
    start_run();
  endtask

  // One instruction starting in FETCH. di/dd are ack delays in cycles;
  // MAX_WAIT or more means the ack never comes.
  task automatic gen(input bit [6:0] op, input int di, input int dd, output bit h);
    bit hr;
    h = 1'b0;
    if (di >= MAX_WAIT) begin
      repeat (MAX_WAIT) emit(0, 0, 0, rb(), rhr(), 0, rb(), rop());
      if (err_m == 0) err_m = 2'd2;
      h = 1'b1;
      return;
    end
    repeat (di) emit(0, 0, 0, rb(), rhr(), 0, rb(), rop());
    emit(0, 0, 0, rb(), rhr(), 1, rb(), rop());
    emit(1, 0, 0, rb(), rhr(), rb(), rb(), op);
    if (!legal(op)) begin
      if (err_m == 0) err_m = 2'd1;
      h = 1'b1;
      return;
    end
    emit(2, 0, 0, rb(), rhr(), rb(), rb(), op);
    if (op == LOAD || op == STORE) begin
      if (dd >= MAX_WAIT) begin
        repeat (MAX_WAIT) emit(3, 1, 0, rb(), rhr(), rb(), 0, op);
        if (err_m == 0) err_m = 2'd3;
        h = 1'b1;
        return;
      end
      repeat (dd) emit(3, 1, 0, rb(), rhr(), rb(), 0, op);
      emit(3, 1, 1, rb(), rhr(), rb(), 1, op);
    end else begin
      emit(3, 0, 1, rb(), rhr(), rb(), rb(), op);
    end
    hr = rhr();
    h  = (op == SYSTEM) || pend || hr;
    emit(4, 0, 0, rb(), hr, rb(), rb(), op);
  endtask

  task automatic tail(input bit h);
    if (h) repeat (2) emit(P_HALT, 0, 0, 1, 0, rb(), rb(), rop());
  endtask

  // Reset the DUT, check the reset state, then replay the timeline.
  task automatic play(input string tag);
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; opcode = '0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_rst_out"}, outv(), RESET_OUT);
    check({tag, "_rst_ccnt"}, cycle_cnt, 0);
    check({tag, "_rst_iret"}, instret, 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tl[i]) begin
      run = tl[i].run; halt_req = tl[i].hr; imem_ack = tl[i].ia;
      dmem_ack = tl[i].da; opcode = tl[i].op;
      #1;
      check($sformatf("%s_c%0d_out", tag, i), outv(), tl[i].expv);
      check($sformatf("%s_c%0d_ccnt", tag, i), cycle_cnt, tl[i].ccnt);
      check($sformatf("%s_c%0d_iret", tag, i), instret, tl[i].iret);
      @(negedge clk);
    end
  endtask

  initial begin
    bit h;
    int r, di, dd;
    bit [6:0] op;

    rst = 1'b1; run = 1'b0; halt_req = 1'b0; opcode = '0;
    imem_ack = 1'b0; dmem_ack = 1'b0;

    // Zero-wait stream, slow fetch, slow load, illegal opcode.
    new_seg(); hr_en = 1'b0;
    start_run();
    repeat (3) gen(IMM, 0, 0, h);
    gen(IMM, 3, 0, h);
    gen(LOAD, 0, 2, h);
    gen(7'b0000000, 0, 0, h);
    tail(h);
    play("dir1");

    // Fetch never acknowledged.
    new_seg();
    start_run();
    gen(IMM, MAX_WAIT, 0, h);
    tail(h);
    play("dir2");

    // Acks on the last allowed cycle, ECALL, restart, data timeout.
    new_seg();
    start_run();
    gen(IMM, MAX_WAIT - 1, 0, h);
    gen(STORE, 0, MAX_WAIT - 1, h);
    gen(SYSTEM, 0, 0, h);
    halt_idle_run();
    gen(LOAD, 0, MAX_WAIT, h);
    tail(h);
    play("dir3");

    // Randomised instruction stream with halt requests.
    new_seg(); hr_en = 1'b1;
    start_run();
    repeat (300) begin
      r = $urandom_range(0, 99);
      if (r < 8)       op = SYSTEM;
      else if (r < 16) op = rop();
      else if (r < 40) op = rb() ? LOAD : STORE;
      else             op = legal_ops[$urandom_range(0, 11)];
      r  = $urandom_range(0, 99);
      di = (r < 70) ? 0 : (r < 93) ? $urandom_range(1, 4) : $urandom_range(MAX_WAIT - 2, MAX_WAIT + 1);
      r  = $urandom_range(0, 99);
      dd = (r < 70) ? 0 : (r < 93) ? $urandom_range(1, 4) : $urandom_range(MAX_WAIT - 2, MAX_WAIT + 1);
      gen(op, di, dd, h);
      if (h) halt_idle_run();
    end
    play("rnd");

    // Reset asserted mid-EXEC.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
    opcode = IMM; halt_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mid_exec_phase", phase, 2);
    check("rst_mid_exec_ccnt", cycle_cnt, 2);
    rst = 1'b1;
    #1;
    check("rst_async_out", outv(), RESET_OUT);
    check("rst_async_ccnt", cycle_cnt, 0);
    check("rst_async_iret", instret, 0);
    @(negedge clk);
    check("rst_held_out", outv(), RESET_OUT);
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    #1;
    check("rst_after_out", outv(), RESET_OUT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Phase controller for the five-phase multicycle RV64 core. It replaces the free-running 0..4 phase counter with an FSM that stalls on instruction and data memory handshakes and starts and stops execution on command. It halts on ECALL, on an illegal opcode or on a memory timeout, and keeps cycle and retired-instruction counters. It sits beside the datapath and drives the phase code and per-phase enables that the fetch, register file, ALU-out, data memory, writeback and PC registers consume.

Parameters:
MAX_WAIT, 16, maximum cycles a memory request may stay unacknowledged before the sequencer halts with an error
CNT_W, 64, width of the cycle and retired-instruction counters

Ports:
clk  input  1  core clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  level; starts execution from IDLE
halt_req  input  1  external stop request; honoured at an instruction boundary
opcode  input  7  decoded opcode of the current instruction; valid from DECODE onward
imem_req  output  1  instruction fetch request
imem_ack  input  1  instruction memory done
dmem_req  output  1  data access request (loads and stores only)
dmem_ack  input  1  data memory done
phase  output  3  0=FETCH, 1=DECODE, 2=EXEC, 3=MEM, 4=WB, 7=IDLE/HALT
opnd_en  output  1  latch the a/b operand registers (DECODE)
aluout_en  output  1  latch the ALU output register (EXEC)
wb_en  output  1  latch the writeback value (MEM)
rf_we_en  output  1  register-file write window (WB)
pc_en  output  1  load the next PC (WB)
busy  output  1  high in every state except IDLE and HALT
halted  output  1  high in HALT
err  output  2  0=none, 1=illegal opcode, 2=imem timeout, 3=dmem timeout; sticky until rst
cycle_cnt  output  CNT_W  cycles spent outside IDLE and HALT
instret  output  CNT_W  count of completed WB phases

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and all outputs to 0, except phase, which is 7.
  - Counters and err are cleared.
  - A reset mid-instruction abandons the instruction; no pc_en or rf_we_en pulse follows it.
- States and transitions:
  - IDLE -> FETCH when run=1.
  - FETCH -> DECODE on a cycle with imem_ack=1; otherwise stay in FETCH.
  - DECODE -> EXEC.
  - EXEC -> MEM.
  - MEM: for a load (0000011) or store (0100011), stay until dmem_ack=1, then go to WB. For any other opcode, MEM lasts exactly one cycle.
  - WB -> HALT if opcode = 1110011 (ECALL) or halt_req=1 was seen since FETCH; otherwise WB -> FETCH.
  - HALT -> IDLE when run=0. A new run=1 then restarts at FETCH; the PC is not reset by this block.
- Outputs are Moore (decoded from the registered state):
  - imem_req = (state==FETCH).
  - dmem_req = (state==MEM) and the opcode is a load or store.
  - Each enable is high for exactly one cycle per instruction, in its named phase. An enable is never high during a stall cycle except the last (acked) cycle: wb_en asserts on the MEM cycle in which dmem_ack=1, or on the single MEM cycle for non-memory opcodes.
- Latency: with zero-wait memories (ack high on the first request cycle) an instruction takes exactly 5 cycles, and phase follows 0,1,2,3,4 with the same timing as the legacy counter.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0111011, 0011011, 1110011.
  - Any other opcode in DECODE goes to HALT next cycle with err=1.
  - No aluout_en, wb_en, rf_we_en or pc_en is issued for that instruction, and instret is not incremented.
- Timeout:
  - A wait counter counts consecutive un-acked request cycles.
  - When it reaches MAX_WAIT, the FSM goes to HALT with err=2 (FETCH) or err=3 (MEM).
  - The wait counter clears on every state change.
- halt_req is latched into a pending flag. The flag clears on leaving WB and on rst.
- Simultaneous events:
  - An ack arriving in the same cycle as a timeout wins: the transition proceeds and no error is raised.
  - halt_req arriving in the same cycle as WB is honoured at that WB.
  - run=0 mid-instruction has no effect; the instruction completes.
- Counters:
  - cycle_cnt increments every cycle in which busy=1.
  - instret increments on each WB cycle.
  - Both wrap modulo 2^CNT_W.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - phase codes 0..4 and 7;
  - RV64 opcode constants (OP_LOAD, OP_STORE, OP_SYSTEM, ...);
  - err codes.
- One sub-module, seq_wait_timer: the wait counter with MAX_WAIT compare, clear and expire outputs.

Test Plan:
- Zero-wait memories, run=1, opcode=0010011 for three instructions -> phase 0,1,2,3,4 repeating. pc_en high at cycles 4, 9 and 14 after the first FETCH. instret=3 and cycle_cnt=15.
- imem_ack delayed 3 cycles -> FETCH held 4 cycles and imem_req high throughout. The instruction completes in 8 cycles with a single opnd_en pulse.
- Load (0000011) with dmem_ack delayed 2 cycles -> dmem_req high for 3 MEM cycles. wb_en asserts only on the third; WB follows the next cycle.
- Opcode 0000000 at DECODE -> HALT next cycle with err=1 and halted=1. instret is unchanged and there is no pc_en pulse.
- imem_ack never asserted with MAX_WAIT=16 -> HALT entered after 16 FETCH cycles with err=2. An ack arriving on the 16th cycle in a rerun proceeds to DECODE with err=0.
- ECALL (1110011) -> HALT after WB. Then drop run -> IDLE. Assert rst mid-EXEC -> phase=7, all enables 0, counters 0.
